// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic tile sequencer and the array it drives:
//   - ctrl_state_e : sequencer phase encoding
//   - N_DEFAULT    : default array dimension shared with the array
//   - FLUSH_LEN    : flush bubbles needed to drain the skewed wavefront (2N-2)
//   - ROW_W        : weight row select width for the default dimension
//   - flush_len()  : flush length for an arbitrary dimension
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int N_DEFAULT = 3;
  localparam int FLUSH_LEN = 2 * N_DEFAULT - 2;
  localparam int ROW_W     = $clog2(N_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_W,
    STREAM,
    FLUSH,
    COLLECT,
    OUTPUT,
    FIN
  } ctrl_state_e;

  function automatic int flush_len(input int n);
    return 2 * n - 2;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Loadable up-counter with enable, synchronous clear and terminal-count flag.
// Priority: clr > load > en.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (count -> 0)
//   clr      : synchronous clear to 0
//   load     : synchronous load of load_val
//   load_val : value to load
//   en       : count enable
//   term     : terminal value
//   count    : current count
//   tc       : count == term
// -----------------------------------------------------------------------------
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for one N x N systolic MAC tile operation:
//   clear accumulators -> load N weight rows -> stream k_len activation vectors
//   -> flush 2N-2 zero bubbles -> collect N column results -> hand result row
//   downstream -> one-cycle done pulse.
// Ports:
//   clk, reset_n          : clock / asynchronous active-low reset
//   start, k_len          : command pulse and vector count (latched in IDLE)
//   busy                  : high outside IDLE
//   clr_acc               : accumulator clear
//   w_load_en, w_row_sel  : weight row write enable / row index
//   a_valid_in, a_ready   : activation handshake
//   feed_en, zero_inj     : array advance enable / force zero inputs
//   mac_done              : per-column result pulse from the array
//   en_y, out_ready       : result row handshake to downstream
//   done                  : completion pulse
// All outputs decode the state register, except feed_en in STREAM which
// follows a_valid_in directly so the array only advances on real data.
// -----------------------------------------------------------------------------
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 clr_acc,
  output logic                 w_load_en,
  output logic [$clog2(N)-1:0] w_row_sel,
  input  logic                 a_valid_in,
  output logic                 a_ready,
  output logic                 feed_en,
  output logic                 zero_inj,
  input  logic                 mac_done,
  output logic                 en_y,
  input  logic                 out_ready,
  output logic                 done
);

  localparam int SEL_W  = $clog2(N);
  localparam int FL_LEN = flush_len(N);
  localparam int FW     = $clog2(FL_LEN + 1);
  localparam int MW     = $clog2(N + 1);

  ctrl_state_e state, state_nxt;
  logic [KW-1:0] k_reg;

  logic [SEL_W-1:0] row_cnt;
  logic [KW-1:0]    vec_cnt;
  logic [FW-1:0]    flush_cnt;
  logic [MW-1:0]    mac_cnt;
  logic             row_tc, vec_tc, flush_tc, mac_tc;
  logic             in_drain;

  // Only the terminal flags steer the FSM; the raw vector/flush/mac counts
  // are not otherwise needed.
  logic unused_cnt;
  assign unused_cnt = ^{vec_cnt, flush_cnt, mac_cnt};

  assign in_drain = (state == FLUSH) || (state == COLLECT);

  // ---- state / command register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        k_reg <= k_len;
      end
    end
  end

  // ---- phase counters ----
  phase_counter #(.W(SEL_W)) u_row_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state != LOAD_W),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == LOAD_W),
    .term     (SEL_W'(N - 1)),
    .count    (row_cnt),
    .tc       (row_tc)
  );

  // tc marks the last vector: the handshake taken while tc is high is the
  // one that brings the accepted count up to k_reg.
  phase_counter #(.W(KW)) u_vec_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state != STREAM),
    .load     (1'b0),
    .load_val ('0),
    .en       ((state == STREAM) && a_valid_in),
    .term     (k_reg - KW'(1)),
    .count    (vec_cnt),
    .tc       (vec_tc)
  );

  phase_counter #(.W(FW)) u_flush_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state != FLUSH),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == FLUSH),
    .term     (FW'(FL_LEN - 1)),
    .count    (flush_cnt),
    .tc       (flush_tc)
  );

  // Saturates at N: extra pulses once all columns are in are dropped.
  phase_counter #(.W(MW)) u_mac_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (!in_drain),
    .load     (1'b0),
    .load_val ('0),
    .en       (in_drain && mac_done && !mac_tc),
    .term     (MW'(N)),
    .count    (mac_cnt),
    .tc       (mac_tc)
  );

  // ---- next-state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_len == '0) ? FIN : CLR;
      CLR:     state_nxt = LOAD_W;
      LOAD_W:  if (row_tc) state_nxt = STREAM;
      STREAM:  if (a_valid_in && vec_tc) state_nxt = FLUSH;
      FLUSH:   if (flush_tc) state_nxt = COLLECT;
      COLLECT: if (mac_tc) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    busy      = (state != IDLE);
    clr_acc   = 1'b0;
    w_load_en = 1'b0;
    w_row_sel = '0;
    a_ready   = 1'b0;
    feed_en   = 1'b0;
    zero_inj  = 1'b0;
    en_y      = 1'b0;
    done      = 1'b0;
    case (state)
      CLR:     clr_acc = 1'b1;
      LOAD_W: begin
        w_load_en = 1'b1;
        w_row_sel = row_cnt;
      end
      STREAM: begin
        a_ready = 1'b1;
        feed_en = a_valid_in;
      end
      FLUSH, COLLECT: begin
        feed_en  = 1'b1;
        zero_inj = 1'b1;
      end
      OUTPUT:  en_y = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Directed bench for systolic_ctrl (N=3, KW=8). Each operation is driven from
// per-cycle stimulus masks indexed by the cycle number after start is sampled
// (cycle 1 = first cycle after the accepting edge); observed events are
// tallied and compared with hand-derived cycle numbers.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int N  = 3;
  localparam int KW = 8;
  localparam int MW = 512;
  typedef logic [MW-1:0] mask_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy, clr_acc, w_load_en;
  logic [1:0]    w_row_sel;
  logic          a_valid_in, a_ready, feed_en, zero_inj;
  logic          mac_done, en_y, out_ready, done;

  systolic_ctrl #(.N(N), .KW(KW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .clr_acc    (clr_acc),
    .w_load_en  (w_load_en),
    .w_row_sel  (w_row_sel),
    .a_valid_in (a_valid_in),
    .a_ready    (a_ready),
    .feed_en    (feed_en),
    .zero_inj   (zero_inj),
    .mac_done   (mac_done),
    .en_y       (en_y),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic mask_t rng(input int lo, input int hi);
    mask_t m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] outs();
    return {22'd0, busy, clr_acc, w_load_en, w_row_sel, a_ready, feed_en,
            zero_inj, en_y, done};
  endfunction

  // observations of the latest operation
  int clr_first, clr_cnt, wl_first, wl_cnt, row_err;
  int sf_first, sf_cnt, feed_any, hs_cnt, stall_cnt;
  int zi_first, zi_cnt, zi_nofeed, eny_first, eny_cnt;
  int done_cyc, done_cnt, busy_cnt, busy_after;

  task automatic run_op(input logic [KW-1:0] k, input logic [KW-1:0] k_alt,
                        input mask_t vld_m, input mask_t mac_m,
                        input mask_t rdy_m, input mask_t start_m,
                        input int budget);
    bit fin;
    bit seen;
    clr_first = -1; clr_cnt = 0; wl_first = -1; wl_cnt = 0; row_err = 0;
    sf_first = -1; sf_cnt = 0; feed_any = 0; hs_cnt = 0; stall_cnt = 0;
    zi_first = -1; zi_cnt = 0; zi_nofeed = 0; eny_first = -1; eny_cnt = 0;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy_after = -1;
    fin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; k_len = k; a_valid_in = 1'b0; mac_done = 1'b0;
    out_ready = rdy_m[0];
    @(posedge clk);
    for (int n = 1; n <= budget && !fin; n++) begin
      #1;
      start = start_m[n]; k_len = k_alt; a_valid_in = vld_m[n];
      mac_done = mac_m[n]; out_ready = rdy_m[n];
      #1;
      seen = (done_cnt > 0);
      if (clr_acc) begin
        if (clr_cnt == 0) clr_first = n;
        clr_cnt++;
      end
      if (w_load_en) begin
        if (wl_cnt == 0) wl_first = n;
        if (int'(w_row_sel) != wl_cnt) row_err++;
        wl_cnt++;
      end else if (w_row_sel != 2'd0) begin
        row_err++;
      end
      if (feed_en) feed_any++;
      if (feed_en && !zero_inj) begin
        if (sf_cnt == 0) sf_first = n;
        sf_cnt++;
      end
      if (a_valid_in && a_ready) hs_cnt++;
      if (a_ready && !feed_en) stall_cnt++;
      if (zero_inj) begin
        if (zi_cnt == 0) zi_first = n;
        zi_cnt++;
        if (!feed_en) zi_nofeed++;
      end
      if (en_y) begin
        if (eny_cnt == 0) eny_first = n;
        eny_cnt++;
      end
      if (done) begin
        if (done_cnt == 0) done_cyc = n;
        done_cnt++;
      end
      if (busy) busy_cnt++;
      if (seen) begin
        busy_after = int'(busy);
        fin = 1'b1;
      end
      @(posedge clk);
    end
    check_eq("op_complete", fin, 1);
    #1;
    start = 1'b0; a_valid_in = 1'b0; mac_done = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; k_len = '0;
    a_valid_in = 1'b0; mac_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", outs(), 0);
    #3;
    reset_n = 1'b1;

    // ---- 1: nominal k=4 ----
    run_op(8'd4, 8'd4, rng(1, MW-1), rng(13, 15), rng(0, MW-1), '0, 100);
    check_eq("t1_clr_first", clr_first, 1);
    check_eq("t1_clr_cnt", clr_cnt, 1);
    check_eq("t1_wl_first", wl_first, 2);
    check_eq("t1_wl_cnt", wl_cnt, 3);
    check_eq("t1_row_err", row_err, 0);
    check_eq("t1_stream_first", sf_first, 5);
    check_eq("t1_stream_cnt", sf_cnt, 4);
    check_eq("t1_handshakes", hs_cnt, 4);
    check_eq("t1_zi_first", zi_first, 9);
    check_eq("t1_zi_cnt", zi_cnt, 8);
    check_eq("t1_zi_nofeed", zi_nofeed, 0);
    check_eq("t1_eny_first", eny_first, 17);
    check_eq("t1_eny_cnt", eny_cnt, 1);
    check_eq("t1_done_cyc", done_cyc, 18);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_busy_cnt", busy_cnt, 18);
    check_eq("t1_busy_after", busy_after, 0);

    // ---- 2: 3-cycle stall after the 2nd vector ----
    run_op(8'd4, 8'd4, rng(1, 6) | rng(10, MW-1), rng(16, 18), rng(0, MW-1), '0, 100);
    check_eq("t2_stream_first", sf_first, 5);
    check_eq("t2_stream_cnt", sf_cnt, 4);
    check_eq("t2_handshakes", hs_cnt, 4);
    check_eq("t2_stall_cnt", stall_cnt, 3);
    check_eq("t2_zi_first", zi_first, 12);
    check_eq("t2_zi_cnt", zi_cnt, 8);
    check_eq("t2_eny_first", eny_first, 20);
    check_eq("t2_done_cyc", done_cyc, 21);

    // ---- 3: backpressure, start while busy, k_len changed after accept ----
    run_op(8'd4, 8'd1, rng(1, MW-1), rng(13, 15), rng(0, 16) | rng(22, MW-1),
           rng(3, 3) | rng(6, 6) | rng(20, 20), 100);
    check_eq("t3_handshakes", hs_cnt, 4);
    check_eq("t3_clr_cnt", clr_cnt, 1);
    check_eq("t3_eny_first", eny_first, 17);
    check_eq("t3_eny_cnt", eny_cnt, 6);
    check_eq("t3_done_cyc", done_cyc, 23);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_busy_cnt", busy_cnt, 23);
    check_eq("t3_busy_after", busy_after, 0);

    // ---- 4: k_len = 0 ----
    run_op(8'd0, 8'd0, '0, '0, '0, '0, 10);
    check_eq("t4_done_cyc", done_cyc, 1);
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_busy_cnt", busy_cnt, 1);
    check_eq("t4_busy_after", busy_after, 0);
    check_eq("t4_clr_cnt", clr_cnt, 0);
    check_eq("t4_wl_cnt", wl_cnt, 0);
    check_eq("t4_feed_any", feed_any, 0);

    // ---- 5: asynchronous reset in STREAM after 2 vectors ----
    @(posedge clk);
    #1;
    start = 1'b1; k_len = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0; a_valid_in = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    check_eq("t5_pre_reset_busy", busy, 1);
    check_eq("t5_pre_reset_ready", a_ready, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_async_reset_outs", outs(), 0);
    @(posedge clk);
    #2;
    check_eq("t5_reset_hold_outs", outs(), 0);
    a_valid_in = 1'b0;
    reset_n = 1'b1;
    run_op(8'd2, 8'd2, rng(1, MW-1), rng(11, 13), rng(0, MW-1), '0, 100);
    check_eq("t5_handshakes", hs_cnt, 2);
    check_eq("t5_zi_first", zi_first, 7);
    check_eq("t5_eny_first", eny_first, 15);
    check_eq("t5_done_cyc", done_cyc, 16);

    // ---- 6a: mac_done outside FLUSH/COLLECT ignored ----
    run_op(8'd4, 8'd4, rng(1, MW-1), rng(2, 2) | rng(6, 6) | rng(9, 10) | rng(14, 14),
           rng(0, MW-1), '0, 100);
    check_eq("t6a_zi_cnt", zi_cnt, 7);
    check_eq("t6a_eny_first", eny_first, 16);
    check_eq("t6a_done_cyc", done_cyc, 17);

    // ---- 6b: all results in during FLUSH, extra pulses saturate ----
    run_op(8'd4, 8'd4, rng(1, MW-1), rng(9, 13), rng(0, MW-1), '0, 100);
    check_eq("t6b_zi_cnt", zi_cnt, 5);
    check_eq("t6b_eny_first", eny_first, 14);
    check_eq("t6b_done_cyc", done_cyc, 15);

    // ---- 7: maximum k_len ----
    run_op(8'd255, 8'd255, rng(1, MW-1), rng(264, 266), rng(0, MW-1), '0, 400);
    check_eq("t7_handshakes", hs_cnt, 255);
    check_eq("t7_stream_cnt", sf_cnt, 255);
    check_eq("t7_zi_first", zi_first, 260);
    check_eq("t7_eny_first", eny_first, 268);
    check_eq("t7_done_cyc", done_cyc, 269);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Top-level sequencer for one N×N systolic MAC tile operation. It runs these phases in order: accumulator clear, weight load, skewed activation streaming, pipeline flush, then result collection. Collection counts the array's per-column `mac_done` pulses and raises `en_y` for the downstream result writer. It sits between the host/command interface and the systolic array plus its output counter path.

Parameters:
N, 3, array dimension (rows = columns = N); legal range 2..16
KW, 8, width of k_len (maximum activation vectors per tile is 2^KW-1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  command pulse; sampled only in IDLE
k_len  in  KW  number of activation vectors; latched on accepted start
busy  out  1  high in every state except IDLE
clr_acc  out  1  clears all PE accumulators
w_load_en  out  1  weight row write enable
w_row_sel  out  $clog2(N)  weight row being written
a_valid_in  in  1  upstream activation vector valid
a_ready  out  1  controller accepts an activation vector
feed_en  out  1  array shift/MAC enable (array frozen when 0)
zero_inj  out  1  array inputs forced to zero (flush bubbles)
mac_done  in  1  one pulse per column result completed by the array
en_y  out  1  result row ready to downstream
out_ready  in  1  downstream consumed result row
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state):
  - state ← IDLE; all counters ← 0; k_len register ← 0.
  - Every output is 0.
- States and transitions: IDLE → CLR → LOAD_W → STREAM → FLUSH → COLLECT → OUTPUT → FIN → IDLE.
- IDLE:
  - Outputs low.
  - start=1 latches k_len and moves to CLR.
  - start=1 with k_len=0 moves directly to FIN, so done pulses with no array activity.
- CLR: exactly 1 cycle; clr_acc=1.
- LOAD_W: exactly N cycles; w_load_en=1; w_row_sel = 0,1,…,N-1 on consecutive cycles.
- STREAM:
  - a_ready=1, and feed_en = a_valid_in (combinational).
  - Each handshake (a_valid_in & a_ready) increments vec_cnt.
  - The handshake that makes vec_cnt == k_len moves the FSM to FLUSH next cycle.
  - a_valid_in=0 stalls with feed_en=0; there is no timeout.
- FLUSH: exactly 2N-2 cycles with feed_en=1, zero_inj=1, a_ready=0.
- mac_done counting:
  - mac_done pulses are counted in FLUSH and COLLECT; the counter saturates at N.
  - mac_done in any other state is ignored.
- COLLECT:
  - feed_en=1, zero_inj=1.
  - Moves to OUTPUT on the cycle after the count reaches N.
  - If the count already equals N on FLUSH exit, COLLECT lasts 1 cycle.
- OUTPUT:
  - en_y=1, held until out_ready=1 is sampled; then moves to FIN.
  - en_y drops the cycle after out_ready is sampled.
- FIN: exactly 1 cycle; done=1; busy=1; then IDLE.
- Boundary conditions:
  - start while busy is ignored; k_len is not re-latched.
  - A k_len input change after acceptance has no effect.
  - k_len = 2^KW-1: vec_cnt is KW bits wide and the compare is exact, with no wrap.
  - out_ready high before en_y has no effect; it is only sampled in OUTPUT.
- Outputs are Moore (registered state decode), except feed_en in STREAM.
- Latency, no stalls: done asserts 1 + N + k_len + (2N-2) + C + 1 cycles after the cycle in which start is sampled. C = COLLECT length + OUTPUT length.

Decomposition:
- Package systolic_pkg holds:
  - ctrl_state_e enum (IDLE, CLR, LOAD_W, STREAM, FLUSH, COLLECT, OUTPUT, FIN);
  - localparams for FLUSH_LEN = 2N-2 and ROW_W = $clog2(N);
  - the default N shared with the array.
- One sub-module, phase_counter: a loadable up-counter with enable, synchronous clear and terminal-count flag.
  - It is instantiated for the LOAD_W row count, vec_cnt, the flush count and the mac_done count.
- The FSM stays in systolic_ctrl.

Test Plan:
1. N=3, start with k_len=4, a_valid_in held 1, mac_done ×3 during COLLECT, out_ready=1 immediately:
   - clr_acc in cycle 1; w_row_sel 0,1,2 in cycles 2–4; feed_en cycles 5–8 with zero_inj=0; flush cycles 9–12 with zero_inj=1;
   - en_y after the 3rd mac_done; done one cycle after out_ready; busy low afterwards.
2. Stall: k_len=4 with a_valid_in low for 3 cycles after the 2nd vector:
   - feed_en=0 and vec_cnt frozen for exactly 3 cycles;
   - exactly 4 handshakes before FLUSH; total latency grows by 3.
3. Backpressure and repeat start: out_ready held 0 for 5 cycles in OUTPUT; start pulsed while busy:
   - en_y stays 1 for 6 cycles; done pulses once; the second start is ignored and k_len is unchanged.
4. Degenerate length: start with k_len=0:
   - busy=1 for 1 cycle; done=1 in that cycle; clr_acc, w_load_en and feed_en never assert.
5. Reset mid-operation: reset_n asserted low asynchronously in STREAM after 2 vectors:
   - all outputs 0 immediately, not waiting for a clock edge.
   - After release, a new start with k_len=2 completes normally with 2 handshakes.
6. Early and spurious mac_done:
   - mac_done in STREAM is ignored.
   - 3 mac_done pulses inside FLUSH → COLLECT lasts 1 cycle, en_y asserts immediately after FLUSH.
   - A 4th mac_done does not disturb the count (saturation).
